line_window_buf: RTL and testbench
==================================

LINE_WINDOW_BUF -- requirements
Module: line_window_buf

Interface
REQ-001 Parameter DATA_W, default 1, pixel width in bits (1 = binary image).
REQ-002 Parameter LINE_LEN, default 640, pixels per image line; legal range 4..4096.
REQ-003 Parameter ROWS, default 3, window column height in lines; legal range 2..5.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port sof  input  1  start-of-frame strobe, synchronous, one cycle.
REQ-007 Port din_valid  input  1  pixel-accept qualifier; acts as the clock enable of the delay lines.
REQ-008 Port din  input  DATA_W  incoming pixel, raster order.
REQ-009 Port col_out  output  ROWS*DATA_W  window column; slice k holds the pixel k lines above the current one.
REQ-010 Port col_valid  output  1  col_out holds a fully populated column.
REQ-011 Port col_x  output  clog2(LINE_LEN)  column index of col_out.
REQ-012 Port row_y  output  16  line index of slice 0 of col_out within the frame.

Function
REQ-013 The block SHALL implement ROWS-1 cascaded delay lines, each exactly LINE_LEN pixels deep, in circular RAM addressed by one shared column pointer.
REQ-014 The delay lines SHALL advance only on cycles with din_valid=1; with din_valid=0 all RAM contents, pointers and counters hold.
REQ-015 The column pointer SHALL increment per accepted pixel and wrap from LINE_LEN-1 to 0; each wrap SHALL increment the internal line counter (saturating at 65535).
REQ-016 col_out, col_x, row_y and col_valid SHALL be registered, with a latency of exactly 1 clk after the accepting edge.
REQ-017 On a cycle with no accepted pixel, col_valid SHALL be 0 on the following cycle, and col_out/col_x/row_y SHALL hold.
REQ-018 col_out slice 0 SHALL equal the accepted din; slice k SHALL equal the pixel accepted k*LINE_LEN accepts earlier within the same frame.
REQ-019 Slice k SHALL read 0 while the line counter < k (no data from the previous frame leaks through); a per-line fill mask SHALL enforce this, not a RAM clear.
REQ-020 col_valid SHALL be 1 for an accepted pixel only when the line counter >= ROWS-1.
REQ-021 sof SHALL clear the column pointer, line counter and fill mask; if sof and din_valid coincide, that pixel SHALL be column 0 of line 0 of the new frame.
REQ-022 A sof arriving mid-line SHALL abandon the partial line with no error flag; the next frame SHALL start cleanly.
REQ-023 A RAM read and write to the same address in one cycle SHALL return the old (pre-write) data (read-before-write).

Reset
REQ-024 rst_n=0 SHALL asynchronously force col_out=0, col_valid=0, col_x=0, row_y=0, pointer=0, line counter=0 and fill mask=0; RAM contents need not be cleared.
REQ-025 After rst_n deasserts, the block SHALL behave as if sof had just occurred; reset asserted mid-frame SHALL discard that frame.

Verification (DATA_W=8, LINE_LEN=4, ROWS=3)
REQ-026 Reset, then sof, then 12 accepted pixels 1..12 -> col_valid=0 for pixels 1..8; pixel 9 gives col_out slices {9,5,1}, col_valid=1, col_x=0, row_y=2; pixel 12 gives {12,8,4}, col_x=3.
REQ-027 Same stream with din_valid low on alternate cycles -> identical col_out sequence; col_valid pulses only on the cycle after each accept.
REQ-028 Frame A = 12 pixels, then sof coincident with pixel 101, then pixels 102..105 -> pixel 105 gives slices {105,101,0} and col_valid=0.
REQ-029 sof after 6 pixels (mid line 1), then 9 pixels 20..28 -> pixel 28 gives {28,24,20}, col_valid=1, row_y=2.
REQ-030 rst_n pulsed low asynchronously (between edges) during line 2 -> outputs 0 immediately; the following 8 accepts give col_valid=0.
REQ-031 DATA_W=1, LINE_LEN=640, ROWS=3: 3 lines of alternating 0/1 -> at column 0 of line 2, col_out = 3'b000 or 3'b111 matching the input pattern, col_valid=1.

Source files
------------

// File: rtl/line_window_buf.sv
// Sliding window column over ROWS raster lines built from cascaded one-line circular delay lines.
// Outputs registered 1 clk after each accepted pixel; din_valid low stalls all state (no output backpressure).
module line_window_buf #(
    parameter int DATA_W   = 1,
    parameter int LINE_LEN = 640,
    parameter int ROWS     = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sof,
    input  logic                        din_valid,
    input  logic [DATA_W-1:0]           din,
    output logic [ROWS*DATA_W-1:0]      col_out,
    output logic                        col_valid,
    output logic [$clog2(LINE_LEN)-1:0] col_x,
    output logic [15:0]                 row_y
);

    localparam int PW = $clog2(LINE_LEN);
    localparam int NL = ROWS - 1;

    logic [DATA_W-1:0]      mem [NL][LINE_LEN];
    logic [DATA_W-1:0]      tap [NL];

    logic [PW-1:0]          ptr;
    logic [15:0]            line_cnt;
    logic [NL-1:0]          mask;

    logic [PW-1:0]          rd_ptr;
    logic [15:0]            cur_line;
    logic [NL-1:0]          cur_mask;
    logic                   last_col;
    logic [PW-1:0]          ptr_nxt;
    logic [15:0]            line_nxt;
    logic [NL-1:0]          mask_nxt;
    logic [ROWS*DATA_W-1:0] col_nxt;

    // sof takes effect on the same cycle, so a coincident pixel lands at column 0 of line 0
    always_comb begin
        rd_ptr   = sof ? '0 : ptr;
        cur_line = sof ? '0 : line_cnt;
        cur_mask = sof ? '0 : mask;
        last_col = (rd_ptr == PW'(LINE_LEN - 1));
        ptr_nxt  = last_col ? '0 : rd_ptr + 1'b1;
        line_nxt = cur_line;
        mask_nxt = cur_mask;
        if (last_col) begin
            if (cur_line != 16'hFFFF) begin
                line_nxt = cur_line + 16'd1;
            end
            mask_nxt = NL'({cur_mask, 1'b1});
        end
    end

    // Combinational read of the pre-write word gives read-before-write on a shared address
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            tap[k] = mem[k][rd_ptr];
        end
    end

    // Fill mask hides stale RAM contents from earlier frames
    always_comb begin
        col_nxt                = '0;
        col_nxt[DATA_W-1:0]    = din;
        for (int k = 1; k < ROWS; k++) begin
            if (cur_mask[k-1]) begin
                col_nxt[k*DATA_W +: DATA_W] = tap[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (din_valid) begin
            mem[0][rd_ptr] <= din;
            for (int k = 1; k < NL; k++) begin
                mem[k][rd_ptr] <= tap[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            line_cnt  <= '0;
            mask      <= '0;
            col_out   <= '0;
            col_valid <= 1'b0;
            col_x     <= '0;
            row_y     <= '0;
        end else begin
            col_valid <= 1'b0;
            if (din_valid) begin
                ptr       <= ptr_nxt;
                line_cnt  <= line_nxt;
                mask      <= mask_nxt;
                col_out   <= col_nxt;
                col_valid <= (cur_line >= 16'(NL));
                col_x     <= rd_ptr;
                row_y     <= cur_line;
            end else if (sof) begin
                ptr      <= '0;
                line_cnt <= '0;
                mask     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_buf.sv
// Directed bench: 8-bit/4-pixel/3-row instance plus a 1-bit/640-pixel instance.
module tb_line_window_buf;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sof, din_valid;
    logic [7:0]  din;
    logic [23:0] col_out;
    logic        col_valid;
    logic [1:0]  col_x;
    logic [15:0] row_y;

    logic        sof_b, dv_b, din_b;
    logic [2:0]  col_out_b;
    logic        col_valid_b;
    logic [9:0]  col_x_b;
    logic [15:0] row_y_b;

    int checks = 0;
    int errors = 0;

    line_window_buf #(.DATA_W(8), .LINE_LEN(4), .ROWS(3)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .din_valid(din_valid), .din(din),
        .col_out(col_out), .col_valid(col_valid), .col_x(col_x), .row_y(row_y)
    );

    line_window_buf #(.DATA_W(1), .LINE_LEN(640), .ROWS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .sof(sof_b), .din_valid(dv_b), .din(din_b),
        .col_out(col_out_b), .col_valid(col_valid_b), .col_x(col_x_b), .row_y(row_y_b)
    );

    task automatic push(input logic [7:0] px, input logic s);
        din = px; din_valid = 1'b1; sof = s;
        @(posedge clk); #1;
        din_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input logic s);
        din_valid = 1'b0; sof = s;
        @(posedge clk); #1;
        sof = 1'b0;
    endtask

    task automatic push_b(input logic v, input logic s);
        din_b = v; dv_b = 1'b1; sof_b = s;
        @(posedge clk); #1;
        dv_b = 1'b0; sof_b = 1'b0;
    endtask

    // Expected column for pixel p of a stream 1,2,3.. starting at a frame boundary
    function automatic logic [23:0] expcol(input int p);
        logic [7:0] s1, s2;
        s1 = (p > 4) ? 8'(p - 4) : 8'd0;
        s2 = (p > 8) ? 8'(p - 8) : 8'd0;
        return {s2, s1, 8'(p)};
    endfunction

    task automatic test_reset;
        checks++;
        if ({col_out, col_valid, col_x, row_y} !== 43'd0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0", {col_out, col_valid, col_x, row_y});
        end
        checks++;
        if ({col_out_b, col_valid_b, col_x_b, row_y_b} !== 30'd0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0", {col_out_b, col_valid_b, col_x_b, row_y_b});
        end
    endtask

    task automatic test_fill;
        idle(1'b1);
        for (int p = 1; p <= 12; p++) begin
            push(8'(p), 1'b0);
            checks++;
            if (col_valid !== 1'(p >= 9)) begin
                errors++;
                $display("FAIL fill_valid p=%0d got %b exp %b", p, col_valid, p >= 9);
            end
            checks++;
            if (col_out !== expcol(p)) begin
                errors++;
                $display("FAIL fill_col p=%0d got %h exp %h", p, col_out, expcol(p));
            end
            checks++;
            if (col_x !== 2'((p - 1) % 4) || row_y !== 16'((p - 1) / 4)) begin
                errors++;
                $display("FAIL fill_xy p=%0d got x=%0d y=%0d exp x=%0d y=%0d",
                         p, col_x, row_y, (p - 1) % 4, (p - 1) / 4);
            end
        end
        checks++;
        if (col_out !== 24'h04080C) begin
            errors++;
            $display("FAIL fill_px12 got %h exp 04080c", col_out);
        end
    endtask

    task automatic test_gaps;
        idle(1'b1);
        for (int p = 1; p <= 12; p++) begin
            push(8'(p), 1'b0);
            checks++;
            if (col_valid !== 1'(p >= 9) || col_out !== expcol(p)) begin
                errors++;
                $display("FAIL gap_accept p=%0d got %b/%h exp %b/%h", p, col_valid, col_out, p >= 9, expcol(p));
            end
            idle(1'b0);
            checks++;
            if (col_valid !== 1'b0 || col_out !== expcol(p) || col_x !== 2'((p - 1) % 4)) begin
                errors++;
                $display("FAIL gap_hold p=%0d got %b/%h/%0d exp 0/%h/%0d", p, col_valid, col_out, col_x, expcol(p), (p - 1) % 4);
            end
        end
    endtask

    task automatic test_sof_coincident;
        idle(1'b1);
        for (int p = 1; p <= 12; p++) push(8'(p), 1'b0);
        push(8'd101, 1'b1);
        checks++;
        if (col_out !== 24'h000065 || col_valid !== 1'b0 || col_x !== 2'd0 || row_y !== 16'd0) begin
            errors++;
            $display("FAIL sof_px101 got %h/%b/%0d/%0d exp 000065/0/0/0", col_out, col_valid, col_x, row_y);
        end
        for (int p = 102; p <= 105; p++) push(8'(p), 1'b0);
        checks++;
        if (col_out !== 24'h006569 || col_valid !== 1'b0 || row_y !== 16'd1) begin
            errors++;
            $display("FAIL sof_px105 got %h/%b/%0d exp 006569/0/1", col_out, col_valid, row_y);
        end
    endtask

    task automatic test_mid_sof;
        idle(1'b1);
        for (int p = 50; p <= 55; p++) push(8'(p), 1'b0);
        idle(1'b1);
        for (int p = 20; p <= 28; p++) begin
            push(8'(p), 1'b0);
            if (p == 20) begin
                checks++;
                if (col_out !== 24'h000014 || col_x !== 2'd0 || row_y !== 16'd0) begin
                    errors++;
                    $display("FAIL midsof_px20 got %h/%0d/%0d exp 000014/0/0", col_out, col_x, row_y);
                end
            end
        end
        checks++;
        if (col_out !== 24'h14181C || col_valid !== 1'b1 || row_y !== 16'd2 || col_x !== 2'd0) begin
            errors++;
            $display("FAIL midsof_px28 got %h/%b/%0d/%0d exp 14181c/1/2/0", col_out, col_valid, row_y, col_x);
        end
    endtask

    task automatic test_async_reset;
        idle(1'b1);
        for (int p = 1; p <= 10; p++) push(8'(p), 1'b0);
        checks++;
        if (col_valid !== 1'b1 || col_out !== expcol(10)) begin
            errors++;
            $display("FAIL arst_pre got %b/%h exp 1/%h", col_valid, col_out, expcol(10));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({col_out, col_valid, col_x, row_y} !== 43'd0) begin
            errors++;
            $display("FAIL arst_now got %h exp 0", {col_out, col_valid, col_x, row_y});
        end
        #2 rst_n = 1'b1;
        for (int p = 30; p <= 37; p++) begin
            push(8'(p), 1'b0);
            checks++;
            if (col_valid !== 1'b0 || col_x !== 2'((p - 30) % 4) || row_y !== 16'((p - 30) / 4)) begin
                errors++;
                $display("FAIL arst_after p=%0d got %b/%0d/%0d exp 0/%0d/%0d", p, col_valid, col_x, row_y, (p - 30) % 4, (p - 30) / 4);
            end
        end
    endtask

    task automatic test_binary;
        idle(1'b0);
        sof_b = 1'b1; @(posedge clk); #1; sof_b = 1'b0;
        for (int n = 0; n < 1920; n++) begin
            push_b(1'(n % 2), 1'b0);
            if (n == 1279) begin
                checks++;
                if (col_valid_b !== 1'b0) begin
                    errors++;
                    $display("FAIL bin_l1_end got %b exp 0", col_valid_b);
                end
            end
            if (n == 1280) begin
                checks++;
                if (col_out_b !== 3'b000 || col_valid_b !== 1'b1 || col_x_b !== 10'd0 || row_y_b !== 16'd2) begin
                    errors++;
                    $display("FAIL bin_l2_c0 got %b/%b/%0d/%0d exp 000/1/0/2", col_out_b, col_valid_b, col_x_b, row_y_b);
                end
            end
            if (n == 1281) begin
                checks++;
                if (col_out_b !== 3'b111 || col_valid_b !== 1'b1 || col_x_b !== 10'd1) begin
                    errors++;
                    $display("FAIL bin_l2_c1 got %b/%b/%0d exp 111/1/1", col_out_b, col_valid_b, col_x_b);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sof = 1'b0; din_valid = 1'b0; din = '0;
        sof_b = 1'b0; dv_b = 1'b0; din_b = 1'b0;
        #12;
        test_reset;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_fill;
        test_gaps;
        test_sof_coincident;
        test_mid_sof;
        test_async_reset;
        test_binary;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
